// File: rtl/reminder_threshold_ctrl.sv
// rtl/reminder_threshold_ctrl.sv - editable usage-time reminder threshold with sticky reminder flag
// Optional macro THRESHOLD_ZERO_GUARD_EN: a 00:00:00 commit loads the default threshold instead.
module reminder_threshold_ctrl #(
  parameter int DEF_HOUR = 10,
  parameter int DEF_MIN  = 0,
  parameter int DEF_SEC  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       is_standby,
  input  logic       set_sw,
  input  logic       unit_toggle,
  input  logic       inc_pulse,
  input  logic       dec_pulse,
  input  logic       sec_tick,
  input  logic       work_active,
  input  logic       clear_reminder,
  output logic [5:0] hour_th,
  output logic [5:0] min_th,
  output logic [5:0] sec_th,
  output logic [1:0] edit_unit,
  output logic       editing,
  output logic       reminder
);

  localparam logic [5:0]  DH      = 6'(DEF_HOUR);
  localparam logic [5:0]  DM      = 6'(DEF_MIN);
  localparam logic [5:0]  DS      = 6'(DEF_SEC);
  localparam logic [17:0] DEF_CAT = {DH, DM, DS};

  typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, EDIT_S} state_t;
  state_t state, state_nxt;

  logic [5:0]  com_h, com_m, com_s;
  logic [5:0]  sh_h, sh_m, sh_s;
  logic [5:0]  use_h, use_m, use_s;
  logic [5:0]  use_h_nxt, use_m_nxt, use_s_nxt;
  logic [17:0] commit_val;
  logic        load_shadow, do_abort, do_commit, use_sat;

  function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] max,
                                            input logic up, input logic dn);
    if (up && !dn)      return (v == max) ? 6'd0 : v + 6'd1;
    else if (dn && !up) return (v == 6'd0) ? max : v - 6'd1;
    else                return v;
  endfunction

  assign editing     = (state != IDLE);
  assign load_shadow = (state == IDLE) && is_standby && set_sw;
  assign do_abort    = editing && !is_standby;
  assign do_commit   = editing && is_standby && !set_sw;

  always_comb begin
    state_nxt = state;
    edit_unit = 2'd0;
    case (state)
      IDLE:   if (is_standby && set_sw) state_nxt = EDIT_H;
      EDIT_H: if (!is_standby || !set_sw) state_nxt = IDLE;
              else if (unit_toggle) state_nxt = EDIT_M;
      EDIT_M: begin
        edit_unit = 2'd1;
        if (!is_standby || !set_sw) state_nxt = IDLE;
        else if (unit_toggle) state_nxt = EDIT_S;
      end
      EDIT_S: begin
        edit_unit = 2'd2;
        if (!is_standby || !set_sw) state_nxt = IDLE;
        else if (unit_toggle) state_nxt = EDIT_H;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
`ifdef THRESHOLD_ZERO_GUARD_EN
    commit_val = ({sh_h, sh_m, sh_s} == 18'd0) ? DEF_CAT : {sh_h, sh_m, sh_s};
`else
    commit_val = {sh_h, sh_m, sh_s};
`endif
  end

  // Usage counter ripple: seconds carry into minutes, minutes into hours.
  always_comb begin
    use_sat   = (use_h == 6'd63) && (use_m == 6'd59) && (use_s == 6'd59);
    use_h_nxt = use_h;
    use_m_nxt = use_m;
    use_s_nxt = use_s + 6'd1;
    if (use_s == 6'd59) begin
      use_s_nxt = 6'd0;
      use_m_nxt = use_m + 6'd1;
      if (use_m == 6'd59) begin
        use_m_nxt = 6'd0;
        use_h_nxt = use_h + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      {com_h, com_m, com_s} <= DEF_CAT;
      {sh_h, sh_m, sh_s}    <= DEF_CAT;
      {use_h, use_m, use_s} <= 18'd0;
      reminder <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_shadow) begin
        {sh_h, sh_m, sh_s} <= {com_h, com_m, com_s};
      end else if (editing && !do_abort && !do_commit) begin
        case (state)
          EDIT_H:  sh_h <= step_field(sh_h, 6'd23, inc_pulse, dec_pulse);
          EDIT_M:  sh_m <= step_field(sh_m, 6'd59, inc_pulse, dec_pulse);
          EDIT_S:  sh_s <= step_field(sh_s, 6'd59, inc_pulse, dec_pulse);
          default: ;
        endcase
      end
      if (do_commit) {com_h, com_m, com_s} <= commit_val;
      if (clear_reminder) begin
        {use_h, use_m, use_s} <= 18'd0;
        reminder <= 1'b0;
      end else begin
        if (sec_tick && work_active && !use_sat)
          {use_h, use_m, use_s} <= {use_h_nxt, use_m_nxt, use_s_nxt};
        // Fields are in range, so the concatenation orders like h:m:s time.
        if ({use_h, use_m, use_s} >= {com_h, com_m, com_s}) reminder <= 1'b1;
      end
    end
  end

  assign hour_th = editing ? sh_h : com_h;
  assign min_th  = editing ? sh_m : com_m;
  assign sec_th  = editing ? sh_s : com_s;

endmodule

// File: tb/tb_reminder_threshold_ctrl.sv
// tb/tb_reminder_threshold_ctrl.sv - directed checks for reminder_threshold_ctrl
module tb_reminder_threshold_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       is_standby = 1'b0, set_sw = 1'b0, unit_toggle = 1'b0;
  logic       inc_pulse = 1'b0, dec_pulse = 1'b0, sec_tick = 1'b0;
  logic       work_active = 1'b0, clear_reminder = 1'b0;
  logic [5:0] hour_th, min_th, sec_th;
  logic [1:0] edit_unit;
  logic       editing, reminder;

  int n_checks = 0;
  int n_pass   = 0;

  reminder_threshold_ctrl dut (
    .clk(clk), .rst_n(rst_n), .is_standby(is_standby), .set_sw(set_sw),
    .unit_toggle(unit_toggle), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .sec_tick(sec_tick), .work_active(work_active), .clear_reminder(clear_reminder),
    .hour_th(hour_th), .min_th(min_th), .sec_th(sec_th),
    .edit_unit(edit_unit), .editing(editing), .reminder(reminder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock edge, sample 1 ns later, then drop all one-cycle pulses.
  task automatic cyc();
    @(posedge clk);
    #1;
    unit_toggle = 1'b0; inc_pulse = 1'b0; dec_pulse = 1'b0;
    sec_tick = 1'b0; clear_reminder = 1'b0;
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin inc_pulse = 1'b1; cyc(); end
  endtask

  task automatic pulse_dec(input int n);
    for (int i = 0; i < n; i++) begin dec_pulse = 1'b1; cyc(); end
  endtask

  task automatic pulse_tog(input int n);
    for (int i = 0; i < n; i++) begin unit_toggle = 1'b1; cyc(); end
  endtask

  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin sec_tick = 1'b1; cyc(); end
  endtask

  initial begin
    cyc(); cyc();
    rst_n = 1'b1;
    check("rst_hour", hour_th, 10);
    check("rst_min", min_th, 0);
    check("rst_sec", sec_th, 0);
    check("rst_editing", editing, 0);
    check("rst_unit", edit_unit, 0);
    check("rst_reminder", reminder, 0);

    pulse_inc(1);
    check("idle_inc_ignored", hour_th, 10);

    is_standby = 1'b1; set_sw = 1'b1; cyc();
    check("enter_editing", editing, 1);
    check("enter_unit", edit_unit, 0);
    pulse_inc(14);
    check("hour_wrap_up", hour_th, 0);
    pulse_dec(1);
    check("hour_wrap_down", hour_th, 23);
    pulse_inc(1);
    check("hour_back_zero", hour_th, 0);

    pulse_tog(1);
    check("unit_min", edit_unit, 1);
    pulse_dec(1);
    check("min_wrap_down", min_th, 59);
    inc_pulse = 1'b1; dec_pulse = 1'b1; cyc();
    check("inc_dec_cancel", min_th, 59);
    pulse_tog(2);
    check("unit_back_hour", edit_unit, 0);

    is_standby = 1'b0; cyc();
    check("abort_editing", editing, 0);
    check("abort_hour", hour_th, 10);
    check("abort_min", min_th, 0);

    is_standby = 1'b1; cyc();
    pulse_inc(2);
    check("edit_hour12", hour_th, 12);
    is_standby = 1'b0; cyc();
    check("abort12_editing", editing, 0);
    check("abort12_hour", hour_th, 10);

    is_standby = 1'b1; cyc();
    inc_pulse = 1'b1; unit_toggle = 1'b1; cyc();
    check("inc_tog_unit", edit_unit, 1);
    check("inc_tog_hour", hour_th, 11);
    set_sw = 1'b0; is_standby = 1'b0; cyc();
    check("abort_prio_hour", hour_th, 10);

    is_standby = 1'b1; set_sw = 1'b1; cyc();
    pulse_dec(10);
    pulse_tog(2);
    check("unit_sec", edit_unit, 2);
    pulse_inc(5);
    set_sw = 1'b0; cyc();
    check("commit_editing", editing, 0);
    check("commit_hour", hour_th, 0);
    check("commit_sec", sec_th, 5);
    check("commit_rem", reminder, 0);

    pulse_tick(2);
    check("idle_ticks_rem", reminder, 0);
    work_active = 1'b1;
    pulse_tick(4);
    check("tick4_rem", reminder, 0);
    pulse_tick(1);
    check("tick5_same_cycle", reminder, 0);
    cyc();
    check("tick5_rem", reminder, 1);

    clear_reminder = 1'b1; sec_tick = 1'b1; cyc();
    check("clear_rem", reminder, 0);
    cyc();
    check("clear_rem_hold", reminder, 0);
    pulse_tick(4);
    cyc();
    check("usage_cleared", reminder, 0);

    set_sw = 1'b1; cyc();
    pulse_tog(2);
    pulse_dec(5);
    set_sw = 1'b0; cyc();
`ifdef THRESHOLD_ZERO_GUARD_EN
    check("zero_guard_hour", hour_th, 10);
    cyc();
    check("zero_guard_rem", reminder, 0);
`else
    check("zero_commit_hour", hour_th, 0);
    cyc();
    check("zero_commit_rem", reminder, 1);
`endif

    set_sw = 1'b1; cyc();
`ifdef THRESHOLD_ZERO_GUARD_EN
    pulse_dec(5);
`else
    pulse_inc(5);
`endif
    check("mid_edit_hour5", hour_th, 5);
    rst_n = 1'b0; inc_pulse = 1'b1; cyc();
    check("mid_rst_editing", editing, 0);
    check("mid_rst_hour", hour_th, 10);
    check("mid_rst_rem", reminder, 0);
    check("mid_rst_unit", edit_unit, 0);
    rst_n = 1'b1; set_sw = 1'b0; cyc();
    check("post_rst_idle", editing, 0);
    check("post_rst_hour", hour_th, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reminder_threshold_ctrl.md
REMINDER_THRESHOLD_CTRL -- requirements
Module: reminder_threshold_ctrl

Interface
REQ-001 Parameter DEF_HOUR, default 10, sets the committed hour threshold after reset (0..23).
REQ-002 Parameter DEF_MIN, default 0, sets the committed minute threshold after reset (0..59).
REQ-003 Parameter DEF_SEC, default 0, sets the committed second threshold after reset (0..59).
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 is_standby  in  1  level; the appliance is in standby, so editing is permitted.
REQ-007 set_sw  in  1  level; reminder-duration set switch.
REQ-008 unit_toggle  in  1  one-cycle pulse, already debounced; advances the edited unit.
REQ-009 inc_pulse  in  1  one-cycle pulse; +1 to the edited unit.
REQ-010 dec_pulse  in  1  one-cycle pulse; -1 to the edited unit.
REQ-011 sec_tick  in  1  one-cycle 1 Hz strobe.
REQ-012 work_active  in  1  level; the appliance is running, so usage time accumulates.
REQ-013 clear_reminder  in  1  one-cycle pulse; clears the reminder and the usage counter.
REQ-014 hour_th, min_th, sec_th  out  6 each  displayed threshold.
REQ-015 edit_unit  out  2  0 = hour, 1 = min, 2 = sec; 3 is never driven.
REQ-016 editing  out  1  high while in an EDIT state.
REQ-017 reminder  out  1  sticky; usage time has reached the threshold.

Function
REQ-018 The FSM SHALL have states IDLE, EDIT_H, EDIT_M and EDIT_S.
REQ-019 Entering edit:
- Condition: in IDLE with is_standby=1 and set_sw=1.
- Next state: EDIT_H.
- Shadow registers load from the committed registers.
REQ-020 unit_toggle SHALL advance the edit state EDIT_H -> EDIT_M -> EDIT_S -> EDIT_H, one step per pulse.
REQ-021 inc_pulse SHALL add 1 to the selected shadow field, wrapping hour 23->0 and min/sec 59->0.
REQ-022 dec_pulse SHALL subtract 1 from the selected shadow field, wrapping hour 0->23 and min/sec 0->59.
REQ-023 inc_pulse and dec_pulse in the same cycle SHALL leave the shadow field unchanged.
REQ-024 inc/dec and unit_toggle in the same cycle: the inc/dec applies to the currently selected unit, and the unit advances on the same edge.
REQ-025 Commit: set_sw=0 while in an EDIT state SHALL copy the shadow registers into the committed registers and return to IDLE in one cycle.
REQ-026 Abort: is_standby=0 while in an EDIT state SHALL discard the shadow registers, keep the committed registers and return to IDLE; abort has priority over commit.
REQ-027 Outputs hour_th/min_th/sec_th SHALL show the shadow registers while editing=1 and the committed registers otherwise.
REQ-028 Pulses on unit_toggle, inc_pulse or dec_pulse received in IDLE SHALL be ignored.
REQ-029 Usage counter (h:m:s, 6 bits per field):
- Increments by 1 s on each sec_tick while work_active=1, with carry 59->0 into the next field.
- Saturates at 63:59:59.
- Keeps counting while the FSM is editing.
REQ-030 reminder SHALL assert one cycle after the edge on which usage equals or exceeds the committed threshold, and SHALL remain high until clear_reminder or reset.
REQ-031 Comparison SHALL use the committed values only; committing a threshold below the current usage SHALL raise reminder on the next cycle.
REQ-032 clear_reminder SHALL zero the usage counter and deassert reminder, taking priority over a coincident sec_tick.
REQ-033 Values loaded into the threshold registers are always kept within range by the wrap rules, so no out-of-range value can be committed.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force all of the following, including mid-edit:
- state = IDLE, edit_unit = 0, editing = 0.
- committed = shadow = DEF_HOUR:DEF_MIN:DEF_SEC.
- usage counter = 0, reminder = 0.
REQ-035 All inputs other than rst_n SHALL be ignored on a cycle where rst_n=0.

Configuration
REQ-036 Macro THRESHOLD_ZERO_GUARD_EN:
- Defined: a commit of 00:00:00 SHALL instead load DEF_HOUR:DEF_MIN:DEF_SEC into the committed registers.
- Undefined: 00:00:00 SHALL be committed as-is, so reminder asserts one cycle after commit.

Verification
REQ-037 Reset, then enter edit and increment hour 14 times -> hour_th shows 00 (10+14 wraps past 23).
REQ-038 EDIT_M at 00, one dec_pulse -> min_th=59; then toggle twice -> edit_unit=0.
REQ-039 Edit hour to 12, then drop is_standby -> editing=0 and hour_th=10 (committed value unchanged).
REQ-040 Threshold 00:00:05, work_active=1, five sec_tick pulses -> reminder=1 one cycle after the 5th tick; clear_reminder -> reminder=0 and usage=0.
REQ-041 Commit 00:00:00 -> reminder=1 without the macro; with THRESHOLD_ZERO_GUARD_EN, hour_th=10 and reminder stays 0.
REQ-042 Assert rst_n=0 mid-edit with shadow hour=05 -> next cycle: IDLE, hour_th=10, reminder=0.
